// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes,
// FSM states and the default datapath width.
package mult_div_unit_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: yields |x| on the way in when neg
// is the operand sign, and restores the sign of a result on the way out.
module md_sign_fix
  import mult_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per clock, with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = mult_div_unit_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);
  import mult_div_unit_pkg::*;

  localparam int N  = DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e          state;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  acc;
  logic [N-1:0]    opnd;
  logic            is_div_q;
  logic            neg_res;
  logic            neg_rem;
  logic            dz;

  logic            sgn_op;
  logic            start_div;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic [N:0]      mul_sum;
  logic [N:0]      div_shift;
  logic [N:0]      div_diff;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quot;
  logic [N-1:0]    rem;

  assign sgn_op    = ~op[0];
  assign start_div = (op_e'(op) == OP_DIV) || (op_e'(op) == OP_DIVU);

  md_sign_fix #(.W(N))   u_abs_a    (.val(A),            .neg(sgn_op & A[N-1]), .res(a_mag));
  md_sign_fix #(.W(N))   u_abs_b    (.val(B),            .neg(sgn_op & B[N-1]), .res(b_mag));
  md_sign_fix #(.W(2*N)) u_neg_prod (.val(acc),          .neg(neg_res),         .res(prod));
  md_sign_fix #(.W(N))   u_neg_quot (.val(acc[N-1:0]),   .neg(neg_res),         .res(quot));
  md_sign_fix #(.W(N))   u_neg_rem  (.val(acc[2*N-1:N]), .neg(neg_rem),         .res(rem));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opnd : '0)};
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  // The borrow out of div_diff says whether the trial subtraction fits.
  assign div_shift = acc[2*N-1:N-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div_q    <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q <= start_div;
            neg_res  <= sgn_op & (A[N-1] ^ B[N-1]);
            neg_rem  <= sgn_op & A[N-1];
            dz       <= start_div & (B == '0);
            count    <= CW'(N - 1);
            busy     <= 1'b1;
            if (start_div) begin
              opnd  <= b_mag;
              acc   <= {{N{1'b0}}, a_mag};
              state <= DIV;
            end else begin
              opnd  <= a_mag;
              acc   <= {{N{1'b0}}, b_mag};
              state <= MUL;
            end
          end else begin
            if (mthi) HI <= wdata;
            if (mtlo) LO <= wdata;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[N-1:1]};
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        DIV: begin
          acc   <= {(div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0]),
                    acc[N-2:0], ~div_diff[N]};
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          // A zero divisor leaves |A| in the remainder, so rem already equals A.
          if (is_div_q) begin
            HI          <= rem;
            LO          <= dz ? '1 : quot;
            div_by_zero <= dz;
          end else begin
            {HI, LO} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded random/directed bench for mult_div_unit with an arithmetic
// reference model; a negedge monitor checks every done pulse.
module tb_mult_div_unit;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] hi, lo;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   busy_run = 0;
  logic busy_prev = 1'b0;
  int   dc_before;

  mult_div_unit #(.DATA_WIDTH(N)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .A(a), .B(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv);
    exp_t            e;
    longint          sp, sa, sbv, q, r;
    longint unsigned up;
    e.dz  = 1'b0;
    e.cyc = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        {e.hi, e.lo} = sp;
      end
      2'b01: begin
        up = 64'(av) * 64'(bv);
        {e.hi, e.lo} = up;
      end
      default: begin
        if (bv == '0) begin
          e.hi = av;
          e.lo = '1;
          e.dz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = av / bv;
          e.hi = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = '0;
        end else begin
          sa   = $signed(av);
          sbv  = $signed(bv);
          q    = sa / sbv;
          r    = sa % sbv;
          e.lo = 32'(q);
          e.hi = 32'(r);
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (busy) busy_run = busy_prev ? busy_run + 1 : 1;
    busy_prev = busy;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_done: done seen with HI=0x%08h LO=0x%08h, required no pulse", hi, lo);
      end else begin
        e = sb.pop_front();
        check("HI", hi, e.hi);
        check("LO", lo, e.lo);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        check("latency", 32'(cyc - e.cyc), 32'd33);
        check("busy_cycles", 32'(busy_run), 32'd33);
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end else begin
      check("dz_without_done", {31'b0, div_by_zero}, 32'd0);
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv, input logic mv);
    exp_t e;
    wait_idle();
    e     = model(o, av, bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (mv) begin
      mthi  = 1'b1;
      wdata = 32'h0000_BEEF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_HI", hi, 32'd0);
    check("reset_LO", lo, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_dz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    issue(2'b10, 32'h8000_0123, 32'd0, 1'b0);

    // start and mthi while busy must both be ignored
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'h0000_DEAD; b = 32'd3;
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    wait_idle();

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_5555;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_idle", hi, 32'h0000_5555);
    check("mtlo_idle", lo, 32'h0000_5555);

    issue(2'b01, 32'd3, 32'd5, 1'b1);
    check("start_beats_mthi", hi, 32'h0000_5555);

    // reset in the middle of a divide aborts it
    issue(2'b10, 32'd1000, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    dc_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_HI", hi, 32'd0);
    check("abort_LO", lo, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(dc_before));
    sb.delete();
    issue(2'b01, 32'd3, 32'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    begin
      int g;
      g = 0;
      while (sb.size() > 0 && g < 200) begin
        @(negedge clk);
        g++;
      end
      check("drain", 32'(sb.size()), 32'd0);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
